// File: rtl/scanline_controller.sv
// Scanline buffer sequencer: strobes K-1 shared line buffers, tracks row/col, flags full KxK windows.
// Optional build macro SCANLINE_CTRL_STATS_EN adds a saturating stall_count output.
module scanline_controller #(
  parameter int KERNEL_SIZE = 3,
  parameter int MAX_WIDTH   = 512,
  parameter int COORD_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] img_width,
  input  logic [COORD_WIDTH-1:0] img_height,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   lb_enable,
  output logic                   lb_valid,
  output logic [31:0]            lb_length,
  output logic                   win_valid,
  output logic [COORD_WIDTH-1:0] row,
  output logic [COORD_WIDTH-1:0] col,
  output logic                   busy,
  output logic                   cfg_err,
  output logic                   frame_done
`ifdef SCANLINE_CTRL_STATS_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  localparam logic [COORD_WIDTH-1:0] K_M1 = COORD_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [COORD_WIDTH-1:0] K_M2 = COORD_WIDTH'(KERNEL_SIZE - 2);

  state_t                 state_reg;
  logic [COORD_WIDTH-1:0] pos_row_reg, pos_col_reg;
  logic [COORD_WIDTH-1:0] w_last_reg, h_last_reg;
  logic [31:0]            width_ext, height_ext;
  logic                   dims_ok, in_frame, accept, col_last, row_last;

  assign width_ext  = 32'(img_width);
  assign height_ext = 32'(img_height);
  assign dims_ok    = (width_ext >= 32'(KERNEL_SIZE)) && (width_ext <= 32'(MAX_WIDTH)) &&
                      (height_ext >= 32'(KERNEL_SIZE));

  assign in_frame  = (state_reg == PRIME) || (state_reg == STREAM);
  assign in_ready  = in_frame && out_ready;
  assign accept    = in_valid && in_ready;
  assign lb_enable = accept;
  assign lb_valid  = accept;

  // pos_* is the coordinate of the pixel that the next accept will carry
  assign col_last = (pos_col_reg == w_last_reg);
  assign row_last = (pos_row_reg == h_last_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pos_row_reg <= '0;
      pos_col_reg <= '0;
      w_last_reg  <= '0;
      h_last_reg  <= '0;
      lb_length   <= '0;
      win_valid   <= 1'b0;
      row         <= '0;
      col         <= '0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
      win_valid  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (dims_ok) begin
              state_reg   <= PRIME;
              busy        <= 1'b1;
              w_last_reg  <= img_width - COORD_WIDTH'(1);
              h_last_reg  <= img_height - COORD_WIDTH'(1);
              lb_length   <= 32'(img_width - COORD_WIDTH'(1));
              pos_row_reg <= '0;
              pos_col_reg <= '0;
              row         <= '0;
              col         <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        PRIME, STREAM: begin
          if (accept) begin
            win_valid <= (pos_row_reg >= K_M1) && (pos_col_reg >= K_M1);
            row       <= pos_row_reg;
            col       <= pos_col_reg;
            if (col_last) begin
              pos_col_reg <= '0;
              if (!row_last) pos_row_reg <= pos_row_reg + COORD_WIDTH'(1);
            end else begin
              pos_col_reg <= pos_col_reg + COORD_WIDTH'(1);
            end
            // priming ends once the first K-1 lines are in the buffers
            if (state_reg == PRIME && col_last && pos_row_reg == K_M2) state_reg <= STREAM;
            if (state_reg == STREAM && col_last && row_last) begin
              state_reg  <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SCANLINE_CTRL_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (state_reg == IDLE && start && dims_ok) begin
      stall_count <= '0;
    end else if (in_frame && in_valid && !in_ready && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
